// File: rtl/led_pkg.sv
// Shared definitions for the LED bank controller: mode encodings, bank width
// and board clock frequency.
package led_pkg;

    localparam int LED_W  = 6;
    localparam int CLK_HZ = 27000000;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_COUNT: return MODE_SHIFT;
            MODE_SHIFT: return MODE_BLINK;
            MODE_BLINK: return MODE_HOLD;
            default:    return MODE_COUNT;
        endcase
    endfunction

endpackage

// File: rtl/btn_press_detect.sv
// Push-button front end: two-flop synchronizer, rising-edge detect and a
// lockout counter that turns a bouncy press into one registered pulse.
module btn_press_detect #(
    parameter int LOCKOUT = 270000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

    logic [2:0]    sync_q, sync_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          press_q, press_d;
    logic          rise;

    // sync_q[0..1] are the synchronizer, sync_q[2] is the edge-detect history.
    always_comb begin
        sync_d  = {sync_q[1:0], btn_i};
        rise    = sync_q[1] & ~sync_q[2];
        press_d = rise & (lock_q == '0);
        lock_d  = lock_q;
        if (press_d) begin
            lock_d = LW'(LOCKOUT - 1);
        end else if (lock_q != '0) begin
            lock_d = lock_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            lock_q  <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            lock_q  <= lock_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// LED bank controller: pattern-step tick divider plus the four-mode display
// sequencer, advanced by debounced button presses. Drives active-low LEDs.
module led_mode_sequencer #(
    parameter int TICK_DIV = 27000000,
    parameter int LOCKOUT  = 270000,
    parameter int LED_W    = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BTN,
    output logic [LED_W-1:0] oled,
    output logic [1:0]       mode,
    output logic             step
);

    import led_pkg::*;

    localparam int CW = $clog2(TICK_DIV);

    mode_e            mode_q, mode_d;
    logic [LED_W-1:0] pat_q, pat_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             tick;
    logic             press;

    btn_press_detect #(
        .LOCKOUT (LOCKOUT)
    ) u_btn (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_i   (BTN),
        .press_o (press)
    );

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    // A press takes precedence over a coincident tick; the tick is dropped.
    always_comb begin
        mode_d = mode_q;
        pat_d  = pat_q;
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        step_d = 1'b0;
        if (press) begin
            mode_d = next_mode(mode_q);
            cnt_d  = '0;
            case (mode_d)
                MODE_SHIFT: pat_d = LED_W'(1);
                MODE_HOLD:  pat_d = pat_q;
                default:    pat_d = '0;
            endcase
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_COUNT: pat_d = pat_q + LED_W'(1);
                MODE_SHIFT: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                MODE_BLINK: pat_d = ~pat_q;
                default:    pat_d = pat_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q <= MODE_COUNT;
            pat_q  <= '0;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign oled = ~pat_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized and directed bench for led_mode_sequencer against a cycle-level
// behavioural model of the LED controller.
module tb_led_mode_sequencer;

    localparam int TICK_DIV = 4;
    localparam int LOCKOUT  = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTN = 1'b0;
    logic [5:0] oled;
    logic [1:0] mode;
    logic       step;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_mode = 0;
    int m_pat = 0;
    int m_phase = 0;
    bit m_step = 1'b0;
    bit pend = 1'b0;
    int e = 3;
    int last_acc = -100000;
    bit samp [0:8191];

    led_mode_sequencer #(
        .TICK_DIV (TICK_DIV),
        .LOCKOUT  (LOCKOUT),
        .LED_W    (6)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .BTN   (BTN),
        .oled  (oled),
        .mode  (mode),
        .step  (step)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "timeout");
    end

    // Model: BTN seen at edge k becomes a press decision at edge k+2 (if the
    // previous sample was low and LOCKOUT edges have passed since the last
    // accepted press) and changes the mode at edge k+3.
    task automatic model_edge(input bit r, input bit b);
        bit rise, acc, apply, tk;
        e++;
        if (r) begin
            samp[e] = 1'b0; samp[e-1] = 1'b0; samp[e-2] = 1'b0;
            m_mode = 0; m_pat = 0; m_phase = 0; m_step = 1'b0;
            last_acc = -100000; pend = 1'b0;
            return;
        end
        samp[e] = b;
        rise  = samp[e-2] && !samp[e-3];
        acc   = rise && ((e - last_acc) >= LOCKOUT);
        apply = pend;
        pend  = acc;
        if (acc) last_acc = e;
        tk = (m_phase == TICK_DIV - 1);
        if (apply) begin
            m_mode  = (m_mode + 1) % 4;
            m_phase = 0;
            m_step  = 1'b0;
            if (m_mode == 1) m_pat = 1;
            else if (m_mode != 3) m_pat = 0;
        end else if (tk) begin
            m_phase = 0;
            m_step  = 1'b1;
            case (m_mode)
                0: m_pat = (m_pat + 1) % 64;
                1: m_pat = (m_pat == 32) ? 1 : m_pat * 2;
                2: m_pat = 63 - m_pat;
                default: m_pat = m_pat;
            endcase
        end else begin
            m_phase = m_phase + 1;
            m_step  = 1'b0;
        end
    endtask

    function automatic logic [8:0] exp_vec();
        return {~6'(m_pat), 2'(m_mode), m_step};
    endfunction

    task automatic clk_edge(input bit r, input bit b);
        RESET = r;
        BTN   = b;
        @(posedge CLK);
        model_edge(r, b);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got, exp;
        clk_edge(1'b1, 1'b0);
        clk_edge(1'b1, 1'b0);
        vectors++;
        if (oled !== 6'h3F) begin miscompares++; $display("FAIL reset_oled got=%h exp=3f", oled); end
        vectors++;
        if (mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        vectors++;
        if (step !== 1'b0) begin miscompares++; $display("FAIL reset_step got=%b exp=0", step); end
        got = {oled, mode, step}; exp = exp_vec(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL reset_model got=%h exp=%h", got, exp); end
    endtask

    task automatic test_count();
        logic [8:0] got, exp;
        int steps = 0;
        for (int i = 0; i < 300; i++) begin
            clk_edge(1'b0, 1'b0);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL count_seq e=%0d got=%h exp=%h", e, got, exp); end
            if (step === 1'b1) steps++;
            if (i == 255) begin
                vectors++;
                if (steps !== 64) begin miscompares++; $display("FAIL count_steps got=%0d exp=64", steps); end
                vectors++;
                if (oled !== 6'h3F) begin miscompares++; $display("FAIL count_wrap got=%h exp=3f", oled); end
            end
        end
    endtask

    task automatic test_long_hold();
        logic [8:0] got, exp;
        logic [1:0] pm;
        int changes = 0;
        pm = mode;
        for (int i = 0; i < 60; i++) begin
            clk_edge(1'b0, i < 20);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL hold_seq e=%0d got=%h exp=%h", e, got, exp); end
            if (i == 3) begin
                vectors++;
                if (oled !== 6'h3E) begin miscompares++; $display("FAIL hold_shift_init got=%h exp=3e", oled); end
            end
            if (mode !== pm) changes++;
            pm = mode;
        end
        vectors++;
        if (changes !== 1) begin miscompares++; $display("FAIL hold_single_advance got=%0d exp=1", changes); end
        vectors++;
        if (mode !== 2'd1) begin miscompares++; $display("FAIL hold_mode got=%0d exp=1", mode); end
    endtask

    task automatic test_lockout();
        logic [8:0] got, exp;
        logic [1:0] pm;
        int changes = 0;
        pm = mode;
        for (int i = 0; i < 16; i++) begin
            clk_edge(1'b0, (i == 0) || (i == 5));
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL lock_seq e=%0d got=%h exp=%h", e, got, exp); end
            if (mode !== pm) changes++;
            pm = mode;
        end
        vectors++;
        if (changes !== 1) begin miscompares++; $display("FAIL lock_ignored got=%0d exp=1", changes); end
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 12; i++) begin
                clk_edge(1'b0, i == 0);
                got = {oled, mode, step}; exp = exp_vec(); vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL lock_cycle e=%0d got=%h exp=%h", e, got, exp); end
                if (j == 1 && i == 3) begin
                    vectors++;
                    if ({mode, oled} !== {2'd0, 6'h3F}) begin
                        miscompares++;
                        $display("FAIL lock_wrap_mode got mode=%0d oled=%h exp mode=0 oled=3f", mode, oled);
                    end
                end
            end
        end
    endtask

    task automatic test_press_tick();
        logic [8:0] got, exp;
        logic [5:0] pre;
        int steps = 0;
        for (int k = 0; k < 4 && m_mode != 2; k++) begin
            for (int i = 0; i < 14; i++) begin
                clk_edge(1'b0, i == 0);
                got = {oled, mode, step}; exp = exp_vec(); vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL pt_setup e=%0d got=%h exp=%h", e, got, exp); end
            end
        end
        vectors++;
        if (mode !== 2'd2) begin miscompares++; $display("FAIL pt_blink got=%0d exp=2", mode); end
        for (int k = 0; k < 8 && m_phase != 0; k++) begin
            clk_edge(1'b0, 1'b0);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL pt_align e=%0d got=%h exp=%h", e, got, exp); end
        end
        pre = ~oled;
        clk_edge(1'b0, 1'b1);
        clk_edge(1'b0, 1'b0);
        clk_edge(1'b0, 1'b0);
        got = {oled, mode, step}; exp = exp_vec(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL pt_pre e=%0d got=%h exp=%h", e, got, exp); end
        clk_edge(1'b0, 1'b0);
        vectors++;
        if ({mode, oled, step} !== {2'd3, ~pre, 1'b0}) begin
            miscompares++;
            $display("FAIL pt_collide got mode=%0d oled=%h step=%b exp mode=3 oled=%h step=0", mode, oled, step, ~pre);
        end
        for (int i = 0; i < 40; i++) begin
            clk_edge(1'b0, 1'b0);
            vectors++;
            if (oled !== ~pre) begin miscompares++; $display("FAIL pt_hold_pat got=%h exp=%h", oled, ~pre); end
            if (step === 1'b1) steps++;
        end
        vectors++;
        if (steps !== 10) begin miscompares++; $display("FAIL pt_hold_steps got=%0d exp=10", steps); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] got, exp;
        for (int k = 0; k < 4 && m_mode != 1; k++) begin
            for (int i = 0; i < 14; i++) begin
                clk_edge(1'b0, i == 0);
                got = {oled, mode, step}; exp = exp_vec(); vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL rm_setup e=%0d got=%h exp=%h", e, got, exp); end
            end
        end
        for (int k = 0; k < 40 && !(m_pat == 8 && m_phase == 0); k++) begin
            clk_edge(1'b0, 1'b0);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL rm_wait e=%0d got=%h exp=%h", e, got, exp); end
        end
        vectors++;
        if ({mode, oled} !== {2'd1, 6'h37}) begin
            miscompares++;
            $display("FAIL rm_shift8 got mode=%0d oled=%h exp mode=1 oled=37", mode, oled);
        end
        for (int i = 0; i < 3; i++) clk_edge(1'b0, 1'b1);
        clk_edge(1'b1, 1'b1);
        vectors++;
        if ({oled, mode, step} !== {6'h3F, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rm_reset got oled=%h mode=%0d step=%b exp oled=3f mode=0 step=0", oled, mode, step);
        end
        for (int i = 0; i < 4; i++) begin
            clk_edge(1'b0, 1'b1);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL rm_after e=%0d got=%h exp=%h", e, got, exp); end
        end
        vectors++;
        if ({mode, oled} !== {2'd1, 6'h3E}) begin
            miscompares++;
            $display("FAIL rm_press_after_reset got mode=%0d oled=%h exp mode=1 oled=3e", mode, oled);
        end
        for (int i = 0; i < 12; i++) clk_edge(1'b0, 1'b0);
    endtask

    task automatic test_toggle();
        logic [8:0] got, exp;
        logic [1:0] pm;
        int last_chg = -1;
        for (int i = 0; i < 12; i++) clk_edge(1'b0, 1'b0);
        pm = mode;
        for (int i = 0; i < 30; i++) begin
            clk_edge(1'b0, (i % 2) == 0);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL toggle_seq e=%0d got=%h exp=%h", e, got, exp); end
            if (mode !== pm) begin
                vectors++;
                if (mode !== pm + 2'd1) begin miscompares++; $display("FAIL toggle_skip got=%0d exp=%0d", mode, pm + 2'd1); end
                if (last_chg >= 0) begin
                    vectors++;
                    if (i - last_chg < LOCKOUT) begin
                        miscompares++;
                        $display("FAIL toggle_gap got=%0d exp>=%0d", i - last_chg, LOCKOUT);
                    end
                end
                last_chg = i;
            end
            pm = mode;
        end
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        bit b = 1'b0;
        bit r;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            r = ($urandom_range(0, 149) == 0);
            clk_edge(r, b);
            got = {oled, mode, step}; exp = exp_vec(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL random e=%0d got=%h exp=%h", e, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_long_hold();
        test_lockout();
        test_press_tick();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller for the 6-bit board LED bank. Owns the pattern register and the on-time tick divider, and sequences the bank through four display modes: binary count, rotating single light, blink, and hold. A user push-button advances the mode. Sits directly under the board top; drives the active-low LED pins.

Parameters:
TICK_DIV, 27000000, CLK cycles per pattern step (1 s at 27 MHz); legal range 2..2^25.
LOCKOUT, 270000, CLK cycles after an accepted press during which further presses are ignored (10 ms debounce).
LED_W, 6, number of LEDs. Fixed at 6 for this board; other values are not supported.

Ports:
CLK  input  1  system clock, 27 MHz
RESET  input  1  synchronous, active-high reset
BTN  input  1  raw asynchronous push-button, active-high (board inversion handled at top)
oled  output  6  LED drive, active-low (oled = ~pat)
mode  output  2  current mode: 0 COUNT, 1 SHIFT, 2 BLINK, 3 HOLD
step  output  1  one-cycle pulse on every pattern-advance tick

Behaviour:
- Reset: while RESET is high at a CLK edge, the block loads pat=0, mode=COUNT, tick counter=0, lockout counter=0 and sync flops=0. Outputs after reset: oled=6'h3F, mode=0, step=0. RESET has priority over every other event.
- Tick divider: cnt counts 0..TICK_DIV-1 and wraps to 0. Internal tick is asserted while cnt==TICK_DIV-1. The step output is the registered tick, so it is high for one cycle after the tick edge.
- Button path: two-flop synchronizer, then a rising-edge detect (press = s2 & ~s3).
  - A press is accepted only when the lockout counter is 0. Acceptance loads the lockout counter with LOCKOUT-1.
  - The lockout counter decrements to 0 and then holds.
- Press latency: BTN sampled high at edge N gives an accepted press, and mode/pat update at edge N+3.
- Mode advance on an accepted press: COUNT->SHIFT->BLINK->HOLD->COUNT.
  - On the same edge, cnt is cleared to 0 and pat is loaded with the new mode's initial value: COUNT 6'b000000, SHIFT 6'b000001, BLINK 6'b000000, HOLD keeps current pat.
- Pattern update on tick, when no press is accepted on the same edge:
  - COUNT: pat+1, with 63 wrapping to 0 (6-bit modulo).
  - SHIFT: rotate left, with 6'b100000 going to 6'b000001.
  - BLINK: pat = ~pat.
  - HOLD: pat unchanged, but step still pulses.
- Simultaneous accepted press and tick: the press wins, the tick is discarded, and step is not asserted for that tick.
- Button held: produces exactly one press. A release/re-press inside lockout is ignored. A release/re-press after lockout expires is accepted.
- Reset mid-operation: any mode, pattern or lockout state is abandoned and the next cycle matches the post-reset state.
- No combinational path from BTN to any output. oled is a pure inversion of registered pat.

Decomposition:
- Shared package (led_pkg): mode encodings MODE_COUNT/SHIFT/BLINK/HOLD (2-bit), LED_W=6, board clock frequency constant CLK_HZ=27000000.
- One sub-module: btn_press_detect. It contains the synchronizer, edge detect and lockout counter, with parameter LOCKOUT, and outputs a single-cycle press pulse.
- The tick divider and mode/pattern FSM stay in led_mode_sequencer.

Test Plan (TICK_DIV=4, LOCKOUT=8):
1. Reset, BTN=0, run 300 cycles -> oled=3F, then 3E, 3D ... one step every 4 cycles; after 64 ticks pat wraps 63->0 (oled=3F) and step pulses 64 times.
2. BTN high for 20 cycles -> mode=1 at edge N+3, pat=000001 (oled=3E), cnt=0; ticks then give 000010, 000100 ... 100000 -> 000001; only one mode advance despite the long hold.
3. Press twice 5 cycles apart (second inside lockout) -> only one advance. Press again after 10 cycles -> mode advances; sequence through 4 presses returns mode to 0 with pat=0.
4. In BLINK, align an accepted press with cnt==3 -> mode=HOLD, pat unchanged, no step that edge; in HOLD, pat constant over 40 cycles while step keeps pulsing every 4 cycles.
5. In SHIFT with pat=001000, assert RESET for 1 cycle concurrent with a tick and a press -> next cycle pat=0, mode=0, oled=3F, step=0, lockout=0; an immediate press is accepted.
6. Toggle BTN every cycle for 30 cycles from idle -> at most one accepted press per lockout window; mode never skips a state.
